// File: rtl/dsi_lane_hs_if.sv
// Byte-lane word stream from the packet assembler into the HS lane controller.
interface dsi_lane_hs_if #(
   parameter int LANES = 2
);
   logic               in_valid;
   logic               in_ready;
   logic [8*LANES-1:0] in_data;
   logic [LANES-1:0]   in_keep;
   logic               in_last;

   modport master (
      output in_valid, in_data, in_keep, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_data, in_keep, in_last,
      output in_ready
   );
endinterface

// File: rtl/dsi_lane_hs_ctrl.sv
// D-PHY data-lane HS burst sequencer: FIFO-buffered byte-lane words,
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11.
module dsi_lane_hs_ctrl #(
   parameter int         LANES      = 2,
   parameter int         FIFO_DEPTH = 16,
   parameter int         TIMER_W    = 8,
   parameter logic [7:0] SYNC_BYTE  = 8'hB8
) (
   input  logic                        clk_base,
   input  logic                        reset,
   input  logic [TIMER_W-1:0]          cfg_t_lpx,
   input  logic [TIMER_W-1:0]          cfg_t_prepare,
   input  logic [TIMER_W-1:0]          cfg_t_zero,
   input  logic [TIMER_W-1:0]          cfg_t_trail,
   input  logic [TIMER_W-1:0]          cfg_t_exit,
   dsi_lane_hs_if.slave                s,
   output logic [8*LANES-1:0]          hs_data,
   output logic [LANES-1:0]            hs_oe,
   output logic [LANES-1:0]            lp_p,
   output logic [LANES-1:0]            lp_n,
   output logic [LANES-1:0]            lp_oe,
   output logic                        active,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + LANES + 8*LANES;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, LPX, PREPARE, ZERO, SYNC, DATA, TRAIL, EXIT
   } state_t;

   state_t state, state_nx;
   logic [TIMER_W-1:0] tmr, tmr_nx;

   logic [EW-1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count, pkt_cnt;
   logic               push, pop, full, empty, uflow;
   logic               head_last;
   logic [LANES-1:0]   head_keep;
   logic [8*LANES-1:0] head_data;

   logic [8*LANES-1:0] trail, trail_nx;
   logic               shown_last, shown_last_nx;
   logic [8*LANES-1:0] hs_nx;
   logic [LANES-1:0]   hs_oe_nx, lp_p_nx, lp_n_nx, lp_oe_nx;

   function automatic logic [TIMER_W-1:0] ld(input logic [TIMER_W-1:0] v);
      return (v == '0) ? TIMER_W'(1) : v;
   endfunction

   assign full       = count == FULL_LVL;
   assign empty      = count == '0;
   assign s.in_ready = !full;
   assign push       = s.in_valid && !full;
   assign fifo_level = count;
   assign {head_last, head_keep, head_data} = mem[rd_ptr];

   always_comb begin
      state_nx      = state;
      tmr_nx        = tmr - TIMER_W'(1);
      pop           = 1'b0;
      uflow         = 1'b0;
      shown_last_nx = shown_last;
      unique case (state)
         IDLE:
            if (pkt_cnt != '0 || full) begin
               state_nx = LPX;
               tmr_nx   = ld(cfg_t_lpx);
            end
         LPX:
            if (tmr == TIMER_W'(1)) begin
               state_nx = PREPARE;
               tmr_nx   = ld(cfg_t_prepare);
            end
         PREPARE:
            if (tmr == TIMER_W'(1)) begin
               state_nx = ZERO;
               tmr_nx   = ld(cfg_t_zero);
            end
         ZERO:
            if (tmr == TIMER_W'(1)) state_nx = SYNC;
         SYNC, DATA: begin
            // the word shown this cycle was popped at the previous edge
            if (state == DATA && shown_last) begin
               state_nx = TRAIL;
               tmr_nx   = ld(cfg_t_trail);
            end else if (empty) begin
               uflow    = 1'b1;
               state_nx = TRAIL;
               tmr_nx   = ld(cfg_t_trail);
            end else begin
               pop           = 1'b1;
               state_nx      = DATA;
               shown_last_nx = head_last;
            end
         end
         TRAIL:
            if (tmr == TIMER_W'(1)) begin
               state_nx = EXIT;
               tmr_nx   = ld(cfg_t_exit);
            end
         EXIT:
            if (tmr == TIMER_W'(1)) state_nx = IDLE;
      endcase
   end

   always_comb begin
      hs_nx    = '0;
      hs_oe_nx = '0;
      lp_p_nx  = '1;
      lp_n_nx  = '1;
      lp_oe_nx = '1;
      trail_nx = trail;
      if (state_nx inside {ZERO, SYNC, DATA, TRAIL}) begin
         hs_oe_nx = '1;
         lp_oe_nx = '0;
         lp_p_nx  = '0;
         lp_n_nx  = '0;
      end
      unique case (state_nx)
         LPX:
            lp_p_nx = '0;
         PREPARE: begin
            lp_p_nx = '0;
            lp_n_nx = '0;
         end
         SYNC: begin
            hs_nx    = {LANES{SYNC_BYTE}};
            trail_nx = {LANES{{8{~SYNC_BYTE[7]}}}};
         end
         DATA:
            for (int i = 0; i < LANES; i++) begin
               if (head_keep[i]) begin
                  hs_nx[8*i +: 8]    = head_data[8*i +: 8];
                  trail_nx[8*i +: 8] = {8{~head_data[8*i+7]}};
               end else begin
                  hs_nx[8*i +: 8] = trail[8*i +: 8];
               end
            end
         TRAIL:
            hs_nx = trail;
         default: ;
      endcase
   end

   always_ff @(posedge clk_base) begin
      if (reset) begin
         state      <= IDLE;
         tmr        <= '0;
         hs_data    <= '0;
         hs_oe      <= '0;
         lp_p       <= '1;
         lp_n       <= '1;
         lp_oe      <= '1;
         active     <= 1'b0;
         underrun   <= 1'b0;
         trail      <= '0;
         shown_last <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pkt_cnt    <= '0;
      end else begin
         state      <= state_nx;
         tmr        <= tmr_nx;
         hs_data    <= hs_nx;
         hs_oe      <= hs_oe_nx;
         lp_p       <= lp_p_nx;
         lp_n       <= lp_n_nx;
         lp_oe      <= lp_oe_nx;
         active     <= state_nx != IDLE;
         underrun   <= uflow;
         trail      <= trail_nx;
         shown_last <= shown_last_nx;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count   <= count + (AW+1)'(push) - (AW+1)'(pop);
         pkt_cnt <= pkt_cnt + (AW+1)'(push && s.in_last)
                            - (AW+1)'(pop && head_last);
      end
   end

   always_ff @(posedge clk_base) begin
      if (push) mem[wr_ptr] <= {s.in_last, s.in_keep, s.in_data};
   end
endmodule

// File: tb/tb_dsi_lane_hs_ctrl.sv
// Scoreboard bench for dsi_lane_hs_ctrl (LANES=2, FIFO_DEPTH=16).
module tb_dsi_lane_hs_ctrl;
   logic clk_base = 1'b0;
   logic reset;
   logic [7:0] cfg_t_lpx, cfg_t_prepare, cfg_t_zero, cfg_t_trail, cfg_t_exit;
   logic [15:0] hs_data;
   logic [1:0]  hs_oe, lp_p, lp_n, lp_oe;
   logic        active, underrun;
   logic [4:0]  fifo_level;

   dsi_lane_hs_if #(.LANES(2)) bus ();

   dsi_lane_hs_ctrl #(
      .LANES(2), .FIFO_DEPTH(16), .TIMER_W(8), .SYNC_BYTE(8'hB8)
   ) dut (
      .clk_base(clk_base), .reset(reset),
      .cfg_t_lpx(cfg_t_lpx), .cfg_t_prepare(cfg_t_prepare),
      .cfg_t_zero(cfg_t_zero), .cfg_t_trail(cfg_t_trail),
      .cfg_t_exit(cfg_t_exit), .s(bus),
      .hs_data(hs_data), .hs_oe(hs_oe), .lp_p(lp_p), .lp_n(lp_n),
      .lp_oe(lp_oe), .active(active), .underrun(underrun),
      .fifo_level(fifo_level)
   );

   always #5 clk_base = ~clk_base;

   typedef struct packed {
      logic       act;
      logic       und;
      logic [1:0] hs_oe;
      logic [1:0] lp_p;
      logic [1:0] lp_n;
      logic [1:0] lp_oe;
      logic [15:0] hs;
   } obs_t;

   obs_t sb[$];
   logic [15:0] wd[$];
   logic [1:0]  wk[$];
   int tl, tp, tz, tt, te;
   int checks = 0;
   int passes = 0;

   function automatic int mx(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic set_cfg(input int a, b, c, d, e);
      tl = a; tp = b; tz = c; tt = d; te = e;
      cfg_t_lpx = 8'(a); cfg_t_prepare = 8'(b); cfg_t_zero = 8'(c);
      cfg_t_trail = 8'(d); cfg_t_exit = 8'(e);
   endtask

   task automatic mw(input logic [15:0] d, input logic [1:0] k);
      wd.push_back(d);
      wk.push_back(k);
   endtask

   // expected per-cycle outputs of one burst, from LPX through one IDLE cycle
   task automatic expect_burst(input bit und);
      obs_t e;
      logic [7:0] tr [2];
      logic [7:0] b;
      e = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 16'h0};
      repeat (mx(tl)) sb.push_back(e);
      e.lp_n = 2'b00;
      repeat (mx(tp)) sb.push_back(e);
      e.hs_oe = 2'b11; e.lp_oe = 2'b00;
      repeat (mx(tz)) sb.push_back(e);
      e.hs = 16'hB8B8;
      sb.push_back(e);
      tr[0] = 8'h00; tr[1] = 8'h00;
      foreach (wd[k]) begin
         for (int l = 0; l < 2; l++) begin
            if (wk[k][l]) begin
               b = wd[k][8*l +: 8];
               tr[l] = {8{~b[7]}};
            end else begin
               b = tr[l];
            end
            e.hs[8*l +: 8] = b;
         end
         sb.push_back(e);
      end
      e.hs = {tr[1], tr[0]};
      e.und = und;
      sb.push_back(e);
      e.und = 1'b0;
      repeat (mx(tt) - 1) sb.push_back(e);
      e = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 16'h0};
      repeat (mx(te)) sb.push_back(e);
      e.act = 1'b0;
      sb.push_back(e);
      wd.delete();
      wk.delete();
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_keep  = k;
      bus.in_last  = l;
      while (!bus.in_ready && t < 200) begin
         @(posedge clk_base); #1;
         t++;
      end
      @(posedge clk_base); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_burst(input int chg_idx, input logic [7:0] chg_val);
      obs_t o, e;
      int t = 0;
      int idx = 0;
      @(negedge clk_base);
      while (!active && t < 300) begin
         @(negedge clk_base);
         t++;
      end
      checks++;
      if (!active) begin
         $display("FAIL burst_start active=%b want 1 within 300 cycles", active);
         sb.delete();
         return;
      end
      passes++;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = '{active, underrun, hs_oe, lp_p, lp_n, lp_oe, hs_data};
         checks++;
         if (o !== e)
            $display("FAIL burst[%0d] got act=%b und=%b hs_oe=%b lp=%b%b lp_oe=%b hs=%h want act=%b und=%b hs_oe=%b lp=%b%b lp_oe=%b hs=%h",
                     idx, o.act, o.und, o.hs_oe, o.lp_p, o.lp_n, o.lp_oe, o.hs,
                     e.act, e.und, e.hs_oe, e.lp_p, e.lp_n, e.lp_oe, e.hs);
         else
            passes++;
         if (idx == chg_idx) cfg_t_zero = chg_val;
         idx++;
         if (sb.size() > 0) @(negedge clk_base);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk_base);
      #1 reset = 1'b0;
      @(negedge clk_base);
      checks++;
      if ({bus.in_ready, hs_data, hs_oe, lp_p, lp_n, lp_oe, active, underrun, fifo_level}
          !== {1'b1, 16'h0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 5'd0})
         $display("FAIL reset rdy=%b hs=%h hs_oe=%b lp=%b%b lp_oe=%b act=%b und=%b lvl=%0d want rdy=1 hs=0 hs_oe=00 lp=1111 lp_oe=11 act=0 und=0 lvl=0",
                  bus.in_ready, hs_data, hs_oe, lp_p, lp_n, lp_oe, active, underrun, fifo_level);
      else
         passes++;
   endtask

   task automatic test_basic;
      set_cfg(3, 3, 3, 3, 3);
      mw(16'h2211, 2'b11); mw(16'h4433, 2'b11);
      expect_burst(1'b0);
      send(16'h2211, 2'b11, 1'b0);
      send(16'h4433, 2'b11, 1'b1);
      run_burst(-1, 8'd0);
   endtask

   task automatic test_keep;
      mw(16'h7F10, 2'b11); mw(16'h5580, 2'b01);
      expect_burst(1'b0);
      send(16'h7F10, 2'b11, 1'b0);
      send(16'h5580, 2'b01, 1'b1);
      run_burst(-1, 8'd0);
      mw(16'h3301, 2'b01);
      expect_burst(1'b0);
      send(16'h3301, 2'b01, 1'b1);
      run_burst(-1, 8'd0);
   endtask

   task automatic test_zero_cfg;
      set_cfg(2, 2, 0, 2, 2);
      mw(16'hC3A5, 2'b11);
      expect_burst(1'b0);
      send(16'hC3A5, 2'b11, 1'b1);
      run_burst(-1, 8'd0);
      set_cfg(2, 2, 2, 2, 2);
      mw(16'h1234, 2'b11);
      expect_burst(1'b0);
      send(16'h1234, 2'b11, 1'b1);
      run_burst(4, 8'd5);
      set_cfg(2, 2, 5, 2, 2);
      mw(16'h5678, 2'b11);
      expect_burst(1'b0);
      send(16'h5678, 2'b11, 1'b1);
      run_burst(-1, 8'd0);
   endtask

   task automatic test_fill_underrun;
      set_cfg(1, 1, 1, 1, 1);
      for (int i = 0; i < 3; i++) send({8'(2*i+1), 8'(2*i)}, 2'b11, 1'b0);
      repeat (20) @(negedge clk_base);
      checks++;
      if (active !== 1'b0 || fifo_level !== 5'd3)
         $display("FAIL partial_idle act=%b lvl=%0d want act=0 lvl=3", active, fifo_level);
      else
         passes++;
      for (int i = 3; i < 16; i++) send({8'(2*i+1), 8'(2*i)}, 2'b11, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0 || fifo_level !== 5'd16)
         $display("FAIL full rdy=%b lvl=%0d want rdy=0 lvl=16", bus.in_ready, fifo_level);
      else
         passes++;
      for (int i = 0; i < 16; i++) mw({8'(2*i+1), 8'(2*i)}, 2'b11);
      expect_burst(1'b1);
      run_burst(-1, 8'd0);
      checks++;
      if (fifo_level !== 5'd0 || bus.in_ready !== 1'b1)
         $display("FAIL drained lvl=%0d rdy=%b want lvl=0 rdy=1", fifo_level, bus.in_ready);
      else
         passes++;
   endtask

   task automatic test_back_to_back;
      set_cfg(2, 1, 2, 1, 2);
      mw(16'hA1B2, 2'b11); mw(16'hC3D4, 2'b11);
      expect_burst(1'b0);
      mw(16'hE5F6, 2'b11);
      expect_burst(1'b0);
      fork
         begin
            send(16'hA1B2, 2'b11, 1'b0);
            send(16'hC3D4, 2'b11, 1'b1);
            send(16'hE5F6, 2'b11, 1'b1);
         end
         run_burst(-1, 8'd0);
      join
   endtask

   task automatic test_level_hold;
      set_cfg(1, 1, 1, 1, 1);
      for (int i = 0; i < 9; i++) mw({8'(8'h40+i), 8'(8'h20+i)}, 2'b11);
      expect_burst(1'b0);
      for (int i = 0; i < 9; i++)
         send({8'(8'h40+i), 8'(8'h20+i)}, 2'b11, 1'(i == 8));
      fork
         run_burst(-1, 8'd0);
         begin
            int t = 0;
            @(negedge clk_base);
            while (fifo_level != 5'd8 && t < 100) begin
               @(negedge clk_base);
               t++;
            end
            checks++;
            if (fifo_level !== 5'd8)
               $display("FAIL level8_reach lvl=%0d want 8", fifo_level);
            else
               passes++;
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hAAAA;
            bus.in_keep  = 2'b11;
            bus.in_last  = 1'b0;
            @(negedge clk_base);
            bus.in_valid = 1'b0;
            checks++;
            if (fifo_level !== 5'd8)
               $display("FAIL level8_hold lvl=%0d want 8", fifo_level);
            else
               passes++;
         end
      join
   endtask

   task automatic test_reset_data;
      int t = 0;
      send(16'h1111, 2'b11, 1'b0);
      send(16'h2222, 2'b11, 1'b1);
      @(negedge clk_base);
      while (hs_data !== 16'hAAAA && t < 100) begin
         @(negedge clk_base);
         t++;
      end
      checks++;
      if (hs_data !== 16'hAAAA)
         $display("FAIL reach_data hs=%h want aaaa", hs_data);
      else
         passes++;
      reset = 1'b1;
      @(posedge clk_base); #1;
      checks++;
      if ({lp_p, lp_n, lp_oe, hs_oe, fifo_level, active, bus.in_ready}
          !== {2'b11, 2'b11, 2'b11, 2'b00, 5'd0, 1'b0, 1'b1})
         $display("FAIL reset_data lp=%b%b lp_oe=%b hs_oe=%b lvl=%0d act=%b rdy=%b want lp=1111 lp_oe=11 hs_oe=00 lvl=0 act=0 rdy=1",
                  lp_p, lp_n, lp_oe, hs_oe, fifo_level, active, bus.in_ready);
      else
         passes++;
      reset = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_keep  = 2'b11;
      bus.in_last  = 1'b0;
      set_cfg(3, 3, 3, 3, 3);
      test_reset();
      test_basic();
      test_keep();
      test_zero_cfg();
      test_fill_underrun();
      test_back_to_back();
      test_level_hold();
      test_reset_data();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
